// File: rtl/laundry_floor_station.sv
// Floor-side pickup station: latches button presses, holds the cart for a
// bounded dwell window at a requesting floor, and pulses send on load.
module laundry_floor_station #(
  parameter int DWELL_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [3:0] load_ready,
  input  logic [2:0] at_floor,
  input  logic       wash_done,
  output logic [3:0] req_laundry,
  output logic [3:0] send,
  output logic       busy,
  output logic [7:0] served_count
);

  typedef enum logic [2:0] {IDLE, WAIT_ARRIVE, DWELL, SEND, WAIT_DONE} state_t;

  localparam logic [5:0] DWELL_LAST = 6'(DWELL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  btn_q;
  logic [3:0]  req_q, req_d;
  logic [3:0]  send_q, send_d;
  logic        busy_q;
  logic [7:0]  served_q, served_d;
  logic [5:0]  dwell_q, dwell_d;
  logic [1:0]  k_q, k_d;
  logic        floor_vld;
  logic [1:0]  floor_idx;
  logic        at_k;

  // at_floor values 0,5,6,7 mean "between floors" and must never match
  assign floor_vld = (at_floor >= 3'd1) && (at_floor <= 3'd4);
  assign floor_idx = 2'(at_floor - 3'd1);
  assign at_k      = floor_vld && (floor_idx == k_q);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    dwell_d  = dwell_q;
    served_d = served_q;
    req_d    = req_q;
    case (state_q)
      IDLE: begin
        if (|req_q) state_d = WAIT_ARRIVE;
      end
      WAIT_ARRIVE: begin
        if (req_q == 4'b0000) begin
          state_d = IDLE;
        end else if (floor_vld && req_q[floor_idx]) begin
          k_d     = floor_idx;
          dwell_d = '0;
          state_d = DWELL;
        end
      end
      DWELL: begin
        dwell_d = dwell_q + 6'd1;
        if (!at_k)                      state_d = WAIT_ARRIVE;
        else if (load_ready[k_q])       state_d = SEND;
        else if (dwell_q == DWELL_LAST) state_d = WAIT_ARRIVE;
      end
      SEND: begin
        req_d[k_q] = 1'b0;
        served_d   = served_q + 8'd1;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wash_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // New presses are OR-ed in last so a press coinciding with the clear survives
    req_d  = req_d | (btn & ~btn_q);
    send_d = (state_d == SEND) ? (4'b0001 << k_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      btn_q    <= '0;
      req_q    <= '0;
      send_q   <= '0;
      busy_q   <= 1'b0;
      served_q <= '0;
      dwell_q  <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn;
      req_q    <= req_d;
      send_q   <= send_d;
      busy_q   <= (state_d != IDLE);
      served_q <= served_d;
      dwell_q  <= dwell_d;
      k_q      <= k_d;
    end
  end

  assign req_laundry  = req_q;
  assign send         = send_q;
  assign busy         = busy_q;
  assign served_count = served_q;

endmodule

// File: tb/tb_laundry_floor_station.sv
// Bench for laundry_floor_station: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_laundry_floor_station;

  localparam int DWELL = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = '0;
  logic [3:0] load_ready = '0;
  logic [2:0] at_floor = '0;
  logic       wash_done = 1'b0;
  logic [3:0] req_laundry;
  logic [3:0] send;
  logic       busy;
  logic [7:0] served_count;

  int errors = 0;
  int checks = 0;

  laundry_floor_station #(.DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .reset(reset), .btn(btn), .load_ready(load_ready),
    .at_floor(at_floor), .wash_done(wash_done), .req_laundry(req_laundry),
    .send(send), .busy(busy), .served_count(served_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: phases named after the spec's FSM, kept as plain ints
  localparam int PH_IDLE = 0, PH_ARRIVE = 1, PH_DWELL = 2, PH_SEND = 3, PH_DONE = 4;
  bit [3:0] m_req, m_prev, m_send;
  bit       m_busy;
  int       m_phase, m_floor, m_elapsed, m_served;

  task automatic model_reset();
    m_req = '0; m_prev = '0; m_send = '0; m_busy = 0;
    m_phase = PH_IDLE; m_floor = 0; m_elapsed = 0; m_served = 0;
  endtask

  task automatic model_step();
    bit [3:0] rise;
    bit [3:0] nreq;
    int nphase, f;
    rise   = btn & ~m_prev;
    m_prev = btn;
    nreq   = m_req;
    nphase = m_phase;
    f      = int'(at_floor);
    case (m_phase)
      PH_IDLE:   if (m_req != 0) nphase = PH_ARRIVE;
      PH_ARRIVE: begin
        if (m_req == 0) nphase = PH_IDLE;
        else if (f >= 1 && f <= 4 && m_req[f-1]) begin
          m_floor = f - 1; m_elapsed = 0; nphase = PH_DWELL;
        end
      end
      PH_DWELL: begin
        if (f != m_floor + 1)                nphase = PH_ARRIVE;
        else if (load_ready[m_floor])        nphase = PH_SEND;
        else if (m_elapsed + 1 >= DWELL)     nphase = PH_ARRIVE;
        m_elapsed++;
      end
      PH_SEND: begin
        nreq[m_floor] = 1'b0;
        m_served = (m_served + 1) % 256;
        nphase = PH_DONE;
      end
      PH_DONE:   if (wash_done) nphase = PH_IDLE;
      default:   nphase = PH_IDLE;
    endcase
    m_req   = nreq | rise;
    m_phase = nphase;
    m_send  = (nphase == PH_SEND) ? (4'b0001 << m_floor) : 4'b0000;
    m_busy  = (nphase != PH_IDLE);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; btn = '0; load_ready = '0; at_floor = '0; wash_done = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn = 4'($urandom); load_ready = 4'($urandom);
    at_floor = 3'($urandom); wash_done = 1'($urandom);
    tick(); tick();
    checks++; if (req_laundry !== 4'b0000) begin errors++; $display("FAIL reset_req got=%b exp=0000", req_laundry); end
    checks++; if (send !== 4'b0000) begin errors++; $display("FAIL reset_send got=%b exp=0000", send); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (served_count !== 8'd0) begin errors++; $display("FAIL reset_served got=%0d exp=0", served_count); end
    btn = '0; load_ready = '0; at_floor = '0; wash_done = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    btn = 4'b0100;
    tick();
    checks++; if (req_laundry !== 4'b0100) begin errors++; $display("FAIL press_req got=%b exp=0100", req_laundry); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL press_busy_early got=%b exp=0", busy); end
    btn = '0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL press_busy got=%b exp=1", busy); end
  endtask

  // Continues from test_reset: floor 3 pending, waiting for arrival
  task automatic test_handoff();
    at_floor = 3'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (send !== 4'b0000) begin errors++; $display("FAIL handoff_dwell_send i=%0d got=%b exp=0000", i, send); end
    end
    load_ready = 4'b0100;
    tick();
    checks++; if (send !== 4'b0100) begin errors++; $display("FAIL handoff_send got=%b exp=0100", send); end
    checks++; if (served_count !== 8'd0) begin errors++; $display("FAIL handoff_served_early got=%0d exp=0", served_count); end
    load_ready = '0;
    tick();
    checks++; if (send !== 4'b0000) begin errors++; $display("FAIL handoff_send_single got=%b exp=0000", send); end
    checks++; if (req_laundry !== 4'b0000) begin errors++; $display("FAIL handoff_req got=%b exp=0000", req_laundry); end
    checks++; if (served_count !== 8'd1) begin errors++; $display("FAIL handoff_served got=%0d exp=1", served_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL handoff_busy got=%b exp=1", busy); end
    at_floor = '0; wash_done = 1'b1;
    tick();
    wash_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL handoff_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    btn = 4'b0001;
    tick();
    btn = '0; at_floor = 3'd1;
    tick(); tick();
    for (int i = 0; i < DWELL; i++) begin
      tick();
      checks++; if (send !== 4'b0000) begin errors++; $display("FAIL timeout_send i=%0d got=%b exp=0000", i, send); end
    end
    checks++; if (req_laundry[0] !== 1'b1) begin errors++; $display("FAIL timeout_req got=%b exp=1", req_laundry[0]); end
    load_ready = 4'b0001;
    tick();
    checks++; if (send !== 4'b0000) begin errors++; $display("FAIL timeout_exit got=%b exp=0000", send); end
    tick();
    checks++; if (send !== 4'b0001) begin errors++; $display("FAIL timeout_reenter got=%b exp=0001", send); end
    load_ready = '0;
    tick();
    checks++; if (served_count !== 8'd2) begin errors++; $display("FAIL timeout_served got=%0d exp=2", served_count); end
    wash_done = 1'b1; at_floor = '0;
    tick();
    wash_done = 1'b0;
  endtask

  task automatic test_leave();
    do_reset();
    btn = 4'b0010;
    tick();
    btn = '0; at_floor = 3'd2;
    tick(); tick(); tick();
    at_floor = 3'd0; load_ready = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (send !== 4'b0000) begin errors++; $display("FAIL leave_send i=%0d got=%b exp=0000", i, send); end
    end
    btn = 4'b1111;
    tick();
    btn = '0; at_floor = 3'd6; load_ready = 4'b1111;
    checks++; if (req_laundry !== 4'b1111) begin errors++; $display("FAIL leave_req got=%b exp=1111", req_laundry); end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (send !== 4'b0000) begin errors++; $display("FAIL invalid_floor_send i=%0d got=%b exp=0000", i, send); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL invalid_floor_busy got=%b exp=1", busy); end
  endtask

  task automatic test_simul();
    do_reset();
    btn = 4'b0010;
    tick();
    btn = '0; at_floor = 3'd2; load_ready = 4'b0010;
    tick(); tick(); tick();
    checks++; if (send !== 4'b0010) begin errors++; $display("FAIL simul_send got=%b exp=0010", send); end
    btn = 4'b0010;
    tick();
    checks++; if (req_laundry !== 4'b0010) begin errors++; $display("FAIL simul_setwins got=%b exp=0010", req_laundry); end
    checks++; if (served_count !== 8'd1) begin errors++; $display("FAIL simul_served got=%0d exp=1", served_count); end
    btn = '0;
    tick();
    btn = 4'b1000;
    tick();
    checks++; if (req_laundry !== 4'b1010) begin errors++; $display("FAIL waitdone_latch got=%b exp=1010", req_laundry); end
    btn = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (send !== 4'b0000) begin errors++; $display("FAIL waitdone_send i=%0d got=%b exp=0000", i, send); end
    end
    load_ready = '0; wash_done = 1'b1;
    tick();
    wash_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_idle got=%b exp=0", busy); end
    tick(); tick();
    wash_done = 1'b1;
    tick();
    wash_done = 1'b0; load_ready = 4'b0010;
    tick();
    checks++; if (send !== 4'b0010) begin errors++; $display("FAIL dwell_ignores_wash got=%b exp=0010", send); end
  endtask

  task automatic test_abort();
    do_reset();
    btn = 4'b0100;
    tick();
    btn = '0; at_floor = 3'd3; load_ready = 4'b0100;
    tick(); tick(); tick();
    checks++; if (send !== 4'b0100) begin errors++; $display("FAIL abort_pre_send got=%b exp=0100", send); end
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (send !== 4'b0000) begin errors++; $display("FAIL abort_send got=%b exp=0000", send); end
    checks++; if (req_laundry !== 4'b0000) begin errors++; $display("FAIL abort_req got=%b exp=0000", req_laundry); end
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++; if (send !== 4'b0000 || served_count !== 8'd0) begin
      errors++; $display("FAIL abort_after send=%b served=%0d exp send=0000 served=0", send, served_count);
    end
  endtask

  task automatic test_wrap();
    int sends;
    do_reset();
    sends = 0;
    at_floor = 3'd1; load_ready = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      btn = 4'b0001;
      tick();
      btn = '0;
      for (int j = 0; j < 4; j++) begin
        tick();
        if (send == 4'b0001) sends++;
      end
      wash_done = 1'b1;
      tick();
      wash_done = 1'b0;
      if (i == 254) begin
        checks++; if (served_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", served_count); end
      end
    end
    checks++; if (served_count !== 8'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", served_count); end
    checks++; if (sends !== 256) begin errors++; $display("FAIL wrap_sends got=%0d exp=256", sends); end
    load_ready = '0; at_floor = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) btn = 4'($urandom);
      if ($urandom_range(0, 5) == 0) at_floor = 3'($urandom);
      load_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      wash_done  = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      tick();
      checks++; if (req_laundry !== m_req) begin errors++; $display("FAIL rand_req n=%0d got=%b exp=%b", n, req_laundry, m_req); end
      checks++; if (send !== m_send) begin errors++; $display("FAIL rand_send n=%0d got=%b exp=%b", n, send, m_send); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, m_busy); end
      checks++; if (served_count !== 8'(m_served)) begin errors++; $display("FAIL rand_served n=%0d got=%0d exp=%0d", n, served_count, m_served); end
    end
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_handoff();
    test_timeout();
    test_leave();
    test_simul();
    test_abort();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/laundry_floor_station.md
# laundry_floor_station

Floor-side request/hand-off block for the laundry chute system: it is the other end of the laundry controller's `req_laundry`/`send`/`at_floor`/`wash_done` interface. It latches pickup button presses from four floors and presents them as `req_laundry`. When the cart reaches a requesting floor, it waits a bounded dwell window for the resident to load, then pulses `send` for that floor. It holds off further hand-offs until the controller reports `wash_done`.

## Interface
- `DWELL_CYCLES`, 10, cycles the cart is held at a floor waiting for `load_ready` (legal 1..63)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `btn`  in  4  per-floor pickup buttons, bit i = floor i+1, level, synchronous to `clk`
- `load_ready`  in  4  per-floor "laundry placed in chute" confirmation, level
- `at_floor`  in  3  cart position from controller: 1..4 = floor, 0/5/6/7 = no floor
- `wash_done`  in  1  controller single-cycle pulse, current load finished
- `req_laundry`  out  4  registered pending-pickup flags, one per floor
- `send`  out  4  registered one-hot, single-cycle hand-off pulse
- `busy`  out  1  registered, high whenever FSM not in IDLE
- `served_count`  out  8  registered count of completed hand-offs, wraps 255→0

## Operation
- Request latch: `btn_q` register holds previous `btn`; rising edge on bit i (`btn[i] & ~btn_q[i]`) sets `req_laundry[i]`. Presses on an already-pending floor have no effect. Set happens in every FSM state.
- Clear: `req_laundry[k]` is cleared only in SEND for the captured floor k. If a rising edge on `btn[k]` coincides, set wins (new request stays pending).
- Floor decode: `at_floor` 1..4 maps to index 0..3; any other value is "no floor" and never matches.
- FSM states and transitions:
  - IDLE: `req_laundry != 0` → WAIT_ARRIVE.
  - WAIT_ARRIVE: valid `at_floor` = f with `req_laundry[f-1]` set → capture k = f-1, load dwell counter with 0 → DWELL. If `req_laundry` becomes 0 (only possible through reset), → IDLE.
  - DWELL: counter increments each cycle. Exits are evaluated in priority order:
    - `at_floor` no longer equals k+1 → WAIT_ARRIVE, request kept.
    - `load_ready[k]` high → SEND.
    - counter reaches `DWELL_CYCLES-1` → WAIT_ARRIVE, request kept (missed pickup).
  - SEND: `send[k]` = 1 for this cycle only; clear `req_laundry[k]`; `served_count` += 1 (mod 256) → WAIT_DONE.
  - WAIT_DONE: ignore arrivals and `load_ready`, keep latching buttons. On `wash_done` → IDLE. No timeout.
- `wash_done` outside WAIT_DONE is ignored.
- Dwell counter is 6 bits.
- `send` is never multi-hot and never asserted outside SEND.

## Timing
- Reset (asynchronous assert, synchronous release): `req_laundry`=0, `send`=0, `busy`=0, `served_count`=0, `btn_q`=0, FSM=IDLE, dwell counter=0.
- Reset asserted mid-operation (any state, including SEND) aborts immediately; no `send` pulse is emitted afterward.
- Button latency: rising edge sampled at clock edge N → `req_laundry[i]` high after edge N. FSM leaves IDLE at edge N+1.
- Arrival: matching `at_floor` sampled at edge M → DWELL after M.
- Hand-off: `load_ready[k]` sampled high in DWELL at edge P → `send[k]` high for cycle P..P+1. Both `req_laundry[k]` low and `served_count` updated after edge P+1.
- Dwell timeout: with no `load_ready`, FSM returns to WAIT_ARRIVE exactly `DWELL_CYCLES` cycles after entering DWELL. If the cart is still at the floor, it re-enters DWELL on the next cycle.
- Completion: `wash_done` sampled in WAIT_DONE → IDLE next edge, `busy` low. If requests are pending, WAIT_ARRIVE follows one cycle later.

## Test plan
- Reset: drive `reset`=0 with random inputs → all outputs 0. Release, press `btn`=4'b0100 → `req_laundry`=4'b0100 one cycle later, `busy`=1 the cycle after.
- Normal hand-off: pending floor 3, `at_floor`=3, `load_ready[2]`=1 on dwell cycle 4 → single-cycle `send`=4'b0100, `req_laundry[2]`=0, `served_count`=1. Then `wash_done` pulse → `busy`=0.
- Dwell timeout: pending floor 1, `at_floor`=1 held, `load_ready`=0 → back in WAIT_ARRIVE after exactly 10 cycles, `req_laundry[0]` still 1, no `send`.
- Cart leaves / invalid floor: `at_floor` goes 2→0 mid-dwell → WAIT_ARRIVE, no `send`. Then `at_floor`=6 with all requests pending → no DWELL entry.
- Simultaneous set/clear: `btn[1]` rising edge in the SEND cycle for floor 2 → `send[1]` pulses and `req_laundry[1]` remains 1. Press during WAIT_DONE is latched. `wash_done` while in DWELL is ignored.
- Wrap: 256 completed hand-offs → `served_count` returns to 0.
